// File: rtl/riscv_pkg.sv
// Shared RISC-V decode definitions: opcodes, ALU operation codes, immediate
// formats and the control-bit bundle carried in the ID/EX register.
package riscv_pkg;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_t;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_J    = 3'd3,
    IMM_U    = 3'd4,
    IMM_NONE = 3'd5
  } imm_fmt_t;

  typedef struct packed {
    logic branch;
    logic jump;
    logic memread;
    logic memwrite;
    logic memtoreg;
    logic alusrc;
    logic regwrite;
    logic take;
    logic illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = 9'd0;

  // alt is funct7[5] (instr[30]); it selects SUB/SRA where that encoding exists.
  function automatic alu_op_t f3_to_alu(input logic [2:0] f3, input logic alt);
    alu_op_t op;
    case (f3)
      F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      F3_AND:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/id_imm_gen.sv
// Combinational immediate generator: builds the 32-bit I/S/B/J/U immediate
// and sign-extends it from instruction bit 31 to XLEN.
module id_imm_gen
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  input  imm_fmt_t        fmt_i,
  output logic [XLEN-1:0] imm_o
);

  logic [31:0] imm32_s;
  logic        unused_s;

  // Format-dependent bit gathering into a 32-bit sign-extended value.
  always_comb begin
    imm32_s = 32'd0;
    case (fmt_i)
      IMM_I:    imm32_s = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S:    imm32_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B:    imm32_s = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                           instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_J:    imm32_s = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                           instr_i[20], instr_i[30:21], 1'b0};
      IMM_U:    imm32_s = {instr_i[31:12], 12'd0};
      IMM_NONE: imm32_s = 32'd0;
      default:  imm32_s = 32'd0;
    endcase
  end

  if (XLEN > 32) begin : g_ext
    assign imm_o = {{(XLEN-32){imm32_s[31]}}, imm32_s};
  end else begin : g_noext
    assign imm_o = imm32_s;
  end

  // The opcode bits never contribute to an immediate.
  assign unused_s = ^instr_i[6:0];

endmodule

// File: rtl/id_stage.sv
// RISC-V decode stage with ID/EX register, valid/ready handshake, flush and
// load-use interlock. `define ID_WB_BYPASS_EN forwards write-back data to operands.
module id_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int RAW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  input  logic            if_take,
  output logic            id_ready,
  input  logic            flush,
  output logic [RAW-1:0]  rf_raddr1,
  output logic [RAW-1:0]  rf_raddr2,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  input  logic [RAW-1:0]  wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            wb_we,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [RAW-1:0]  ex_rs1,
  output logic [RAW-1:0]  ex_rs2,
  output logic [RAW-1:0]  ex_rd,
  output logic [3:0]      ex_aluop,
  output logic            ex_branch,
  output logic            ex_jump,
  output logic            ex_memread,
  output logic            ex_memwrite,
  output logic            ex_memtoreg,
  output logic            ex_alusrc,
  output logic            ex_regwrite,
  output logic            ex_take,
  output logic            ex_illegal
);

  logic [6:0]      opc_s;
  logic [2:0]      f3_s;
  logic [RAW-1:0]  rs1_s, rs2_s, rd_s;
  logic            op_ok_s, use1_s, use2_s, wr_s, reg_bad_s, illegal_s;
  logic            hazard_s, accept_s;
  imm_fmt_t        fmt_s;
  alu_op_t         aluop_s;
  ctrl_t           ctrl_s;
  logic [XLEN-1:0] imm_s, rs1_data_s, rs2_data_s;

  logic            valid_q, valid_d;
  ctrl_t           ctrl_q, ctrl_d;
  alu_op_t         aluop_q, aluop_d;
  logic [XLEN-1:0] pc_q, pc_d, imm_q, imm_d, rs1d_q, rs1d_d, rs2d_q, rs2d_d;
  logic [RAW-1:0]  rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;

  assign opc_s = if_instr[6:0];
  assign f3_s  = if_instr[14:12];
  assign rs1_s = if_instr[15 +: RAW];
  assign rs2_s = if_instr[20 +: RAW];
  assign rd_s  = if_instr[7 +: RAW];

  assign rf_raddr1 = rs1_s;
  assign rf_raddr2 = rs2_s;

  // Opcode decode into format, ALU op, operand usage and control bits.
  always_comb begin
    op_ok_s = 1'b0;
    fmt_s   = IMM_NONE;
    aluop_s = ALU_ADD;
    use1_s  = 1'b0;
    use2_s  = 1'b0;
    wr_s    = 1'b0;
    ctrl_s  = CTRL_NONE;
    case (opc_s)
      OP_IMM: begin
        op_ok_s = 1'b1; fmt_s = IMM_I; wr_s = 1'b1; use1_s = 1'b1; ctrl_s.alusrc = 1'b1;
        aluop_s = f3_to_alu(f3_s, (f3_s == F3_SR) && if_instr[30]);
      end
      OP: begin
        op_ok_s = 1'b1; wr_s = 1'b1; use1_s = 1'b1; use2_s = 1'b1;
        aluop_s = f3_to_alu(f3_s, if_instr[30]);
      end
      BRANCH: begin
        op_ok_s = 1'b1; fmt_s = IMM_B; use1_s = 1'b1; use2_s = 1'b1;
        ctrl_s.branch = 1'b1; aluop_s = ALU_SUB;
      end
      JAL: begin
        op_ok_s = 1'b1; fmt_s = IMM_J; wr_s = 1'b1;
        ctrl_s.branch = 1'b1; ctrl_s.jump = 1'b1;
      end
      JALR: begin
        op_ok_s = 1'b1; fmt_s = IMM_I; wr_s = 1'b1; use1_s = 1'b1;
        ctrl_s.branch = 1'b1; ctrl_s.jump = 1'b1; ctrl_s.alusrc = 1'b1;
      end
      LOAD: begin
        op_ok_s = 1'b1; fmt_s = IMM_I; wr_s = 1'b1; use1_s = 1'b1;
        ctrl_s.memread = 1'b1; ctrl_s.memtoreg = 1'b1; ctrl_s.alusrc = 1'b1;
      end
      STORE: begin
        op_ok_s = 1'b1; fmt_s = IMM_S; use1_s = 1'b1; use2_s = 1'b1;
        ctrl_s.memwrite = 1'b1; ctrl_s.alusrc = 1'b1;
      end
      LUI: begin
        op_ok_s = 1'b1; fmt_s = IMM_U; wr_s = 1'b1; ctrl_s.alusrc = 1'b1; aluop_s = ALU_PASSB;
      end
      AUIPC: begin
        op_ok_s = 1'b1; fmt_s = IMM_U; wr_s = 1'b1; ctrl_s.alusrc = 1'b1;
      end
      default: op_ok_s = 1'b0;
    endcase
    // A register field that is actually used must fit in NREG (matters for RV32E).
    reg_bad_s = (use1_s && ((if_instr[19:15] >> RAW) != 5'd0)) ||
                (use2_s && ((if_instr[24:20] >> RAW) != 5'd0)) ||
                (wr_s   && ((if_instr[11:7]  >> RAW) != 5'd0));
    illegal_s       = !op_ok_s || reg_bad_s;
    ctrl_s.regwrite = wr_s && !illegal_s && (rd_s != {RAW{1'b0}});
    ctrl_s.branch   = ctrl_s.branch   && !illegal_s;
    ctrl_s.jump     = ctrl_s.jump     && !illegal_s;
    ctrl_s.memread  = ctrl_s.memread  && !illegal_s;
    ctrl_s.memwrite = ctrl_s.memwrite && !illegal_s;
    ctrl_s.take     = if_take;
    ctrl_s.illegal  = illegal_s;
  end

  id_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr_i (if_instr),
    .fmt_i   (fmt_s),
    .imm_o   (imm_s)
  );

`ifdef ID_WB_BYPASS_EN
  assign rs1_data_s = (wb_we && (wb_rd == rs1_s) && (rs1_s != {RAW{1'b0}})) ? wb_data : rf_rdata1;
  assign rs2_data_s = (wb_we && (wb_rd == rs2_s) && (rs2_s != {RAW{1'b0}})) ? wb_data : rf_rdata2;
`else
  logic unused_wb_s;
  assign rs1_data_s  = rf_rdata1;
  assign rs2_data_s  = rf_rdata2;
  assign unused_wb_s = ^{wb_we, wb_rd, wb_data};
`endif

  assign hazard_s = if_valid && valid_q && ctrl_q.memread && (rd_q != {RAW{1'b0}}) &&
                    ((use1_s && (rd_q == rs1_s)) || (use2_s && (rd_q == rs2_s)));
  assign id_ready = !flush && !hazard_s && (!valid_q || ex_ready);
  assign accept_s = if_valid && id_ready;

  // ID/EX next state: flush, then accept, then drain/bubble, else hold.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    aluop_d = aluop_q;
    pc_d    = pc_q;
    imm_d   = imm_q;
    rs1d_d  = rs1d_q;
    rs2d_d  = rs2d_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_NONE;
    end else if (accept_s) begin
      valid_d = 1'b1;
      ctrl_d  = ctrl_s;
      aluop_d = aluop_s;
      pc_d    = if_pc;
      imm_d   = imm_s;
      rs1d_d  = rs1_data_s;
      rs2d_d  = rs2_data_s;
      rs1_d   = rs1_s;
      rs2_d   = rs2_s;
      rd_d    = rd_s;
    end else if (ex_ready || !valid_q) begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_NONE;
    end else begin
      valid_d = valid_q;
    end
  end

  // ID/EX pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_NONE;
      aluop_q <= ALU_ADD;
      pc_q    <= {XLEN{1'b0}};
      imm_q   <= {XLEN{1'b0}};
      rs1d_q  <= {XLEN{1'b0}};
      rs2d_q  <= {XLEN{1'b0}};
      rs1_q   <= {RAW{1'b0}};
      rs2_q   <= {RAW{1'b0}};
      rd_q    <= {RAW{1'b0}};
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      aluop_q <= aluop_d;
      pc_q    <= pc_d;
      imm_q   <= imm_d;
      rs1d_q  <= rs1d_d;
      rs2d_q  <= rs2d_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_pc       = pc_q;
  assign ex_imm      = imm_q;
  assign ex_rs1_data = rs1d_q;
  assign ex_rs2_data = rs2d_q;
  assign ex_rs1      = rs1_q;
  assign ex_rs2      = rs2_q;
  assign ex_rd       = rd_q;
  assign ex_aluop    = aluop_q;
  assign ex_branch   = ctrl_q.branch;
  assign ex_jump     = ctrl_q.jump;
  assign ex_memread  = ctrl_q.memread;
  assign ex_memwrite = ctrl_q.memwrite;
  assign ex_memtoreg = ctrl_q.memtoreg;
  assign ex_alusrc   = ctrl_q.alusrc;
  assign ex_regwrite = ctrl_q.regwrite;
  assign ex_take     = ctrl_q.take;
  assign ex_illegal  = ctrl_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage (XLEN=64, NREG=32): directed scenarios
// followed by a randomized stream checked against a rule-level reference model.
module tb_id_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid, if_take, flush, wb_we, ex_ready;
  logic [31:0] if_instr;
  logic [63:0] if_pc, rf_rdata1, rf_rdata2, wb_data;
  logic [4:0]  wb_rd, rf_raddr1, rf_raddr2;
  logic        id_ready, ex_valid;
  logic [63:0] ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_aluop;
  logic        ex_branch, ex_jump, ex_memread, ex_memwrite, ex_memtoreg;
  logic        ex_alusrc, ex_regwrite, ex_take, ex_illegal;

  id_stage #(.XLEN(64), .NREG(32)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_take(if_take), .id_ready(id_ready), .flush(flush), .rf_raddr1(rf_raddr1),
    .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_we(wb_we), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_aluop(ex_aluop),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg), .ex_alusrc(ex_alusrc),
    .ex_regwrite(ex_regwrite), .ex_take(ex_take), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [63:0] pc, imm, rs1d, rs2d;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  aluop;
    logic        branch, jump, memread, memwrite, memtoreg, alusrc, regwrite, take, illegal;
  } ex_m_t;

  ex_m_t m;
  int    checks = 0;
  int    errors = 0;
  logic  seen_ready;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic supported(input logic [31:0] ins);
    return ins[6:0] inside {OP_IMM, OP, BRANCH, JAL, JALR, LOAD, STORE, LUI, AUIPC};
  endfunction

  function automatic logic uses1(input logic [31:0] ins);
    return supported(ins) && !(ins[6:0] inside {JAL, LUI, AUIPC});
  endfunction

  function automatic logic uses2(input logic [31:0] ins);
    return ins[6:0] inside {OP, BRANCH, STORE};
  endfunction

  // Reference decode straight from the instruction-set rules.
  function automatic ex_m_t decode(input logic [31:0] ins, input logic [63:0] pc, input logic tk,
                                   input logic [63:0] r1, input logic [63:0] r2, input logic we,
                                   input logic [4:0] wrd, input logic [63:0] wd);
    ex_m_t   d;
    logic [6:0] o;
    int      s, v;
    alu_op_t tab[8];
    tab = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    o = ins[6:0];
    s = int'(ins);
    d.valid    = 1'b1;
    d.pc       = pc;
    d.rs1      = ins[19:15];
    d.rs2      = ins[24:20];
    d.rd       = ins[11:7];
    d.illegal  = !supported(ins);
    d.regwrite = !d.illegal && (o inside {OP_IMM, OP, LOAD, JAL, JALR, LUI, AUIPC}) && (d.rd != 5'd0);
    d.jump     = o inside {JAL, JALR};
    d.branch   = o inside {BRANCH, JAL, JALR};
    d.memread  = (o == LOAD);
    d.memwrite = (o == STORE);
    d.memtoreg = (o == LOAD);
    d.alusrc   = o inside {OP_IMM, LOAD, STORE, JALR, LUI, AUIPC};
    d.take     = tk;
    if (o inside {OP_IMM, JALR, LOAD})  v = s >>> 20;
    else if (o == STORE)               v = ((s >>> 25) <<< 5) | int'(ins[11:7]);
    else if (o == BRANCH)              v = ((s >>> 31) <<< 12) | (int'(ins[7]) << 11) |
                                           (int'(ins[30:25]) << 5) | (int'(ins[11:8]) << 1);
    else if (o == JAL)                 v = ((s >>> 31) <<< 20) | (int'(ins[19:12]) << 12) |
                                           (int'(ins[20]) << 11) | (int'(ins[30:21]) << 1);
    else if (o inside {LUI, AUIPC})    v = s & -4096;
    else                               v = 0;
    d.imm = longint'(v);
    if (o == OP || o == OP_IMM) begin
      d.aluop = tab[ins[14:12]];
      if (ins[14:12] == 3'd5 && ins[30])              d.aluop = ALU_SRA;
      if (ins[14:12] == 3'd0 && ins[30] && o == OP)   d.aluop = ALU_SUB;
    end else if (o == BRANCH) d.aluop = ALU_SUB;
    else if (o == LUI)        d.aluop = ALU_PASSB;
    else                      d.aluop = ALU_ADD;
`ifdef ID_WB_BYPASS_EN
    d.rs1d = (we && wrd == d.rs1 && d.rs1 != 5'd0) ? wd : r1;
    d.rs2d = (we && wrd == d.rs2 && d.rs2 != 5'd0) ? wd : r2;
`else
    d.rs1d = r1;
    d.rs2d = r2;
    if (we && wrd == 5'd31 && wd == 64'd0) d.rs1d = r1;
`endif
    return d;
  endfunction

  function automatic ex_m_t zero_model();
    ex_m_t z;
    z = '{valid: 1'b0, pc: 64'd0, imm: 64'd0, rs1d: 64'd0, rs2d: 64'd0, rs1: 5'd0, rs2: 5'd0,
          rd: 5'd0, aluop: 4'd0, branch: 1'b0, jump: 1'b0, memread: 1'b0, memwrite: 1'b0,
          memtoreg: 1'b0, alusrc: 1'b0, regwrite: 1'b0, take: 1'b0, illegal: 1'b0};
    return z;
  endfunction

  task automatic clear_ctrl();
    m.valid = 1'b0; m.branch = 1'b0; m.jump = 1'b0; m.memread = 1'b0; m.memwrite = 1'b0;
    m.memtoreg = 1'b0; m.alusrc = 1'b0; m.regwrite = 1'b0; m.take = 1'b0; m.illegal = 1'b0;
  endtask

  task automatic check_out();
    chk("ex_valid", ex_valid, m.valid);       chk("ex_pc", ex_pc, m.pc);
    chk("ex_imm", ex_imm, m.imm);             chk("ex_rs1_data", ex_rs1_data, m.rs1d);
    chk("ex_rs2_data", ex_rs2_data, m.rs2d);  chk("ex_rs1", ex_rs1, m.rs1);
    chk("ex_rs2", ex_rs2, m.rs2);             chk("ex_rd", ex_rd, m.rd);
    chk("ex_aluop", ex_aluop, m.aluop);       chk("ex_branch", ex_branch, m.branch);
    chk("ex_jump", ex_jump, m.jump);          chk("ex_memread", ex_memread, m.memread);
    chk("ex_memwrite", ex_memwrite, m.memwrite); chk("ex_memtoreg", ex_memtoreg, m.memtoreg);
    chk("ex_alusrc", ex_alusrc, m.alusrc);    chk("ex_regwrite", ex_regwrite, m.regwrite);
    chk("ex_take", ex_take, m.take);          chk("ex_illegal", ex_illegal, m.illegal);
  endtask

  // One clock: check combinational outputs, advance model at the edge, check registers.
  task automatic step();
    logic  hz, rdy;
    ex_m_t nd;
    #1;
    hz = if_valid && m.valid && m.memread && (m.rd != 5'd0) &&
         ((uses1(if_instr) && m.rd == if_instr[19:15]) || (uses2(if_instr) && m.rd == if_instr[24:20]));
    rdy = !flush && !hz && (!m.valid || ex_ready);
    seen_ready = id_ready;
    chk("id_ready", id_ready, rdy);
    chk("rf_raddr1", rf_raddr1, if_instr[19:15]);
    chk("rf_raddr2", rf_raddr2, if_instr[24:20]);
    nd = decode(if_instr, if_pc, if_take, rf_rdata1, rf_rdata2, wb_we, wb_rd, wb_data);
    @(posedge clk);
    if (flush)                       clear_ctrl();
    else if (if_valid && rdy)        m = nd;
    else if (ex_ready || !m.valid)   clear_ctrl();
    #1;
    check_out();
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] pc, input logic rdy);
    if_valid = v; if_instr = ins; if_pc = pc; ex_ready = rdy;
    if_take = 1'b0; flush = 1'b0; wb_we = 1'b0; wb_rd = 5'd0; wb_data = 64'd0;
    rf_rdata1 = {$urandom, $urandom}; rf_rdata2 = {$urandom, $urandom};
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [6:0]  opcs[11];
    opcs = '{OP_IMM, OP, BRANCH, JAL, JALR, LOAD, STORE, LUI, AUIPC, 7'h7F, 7'h0F};
    ins = $urandom;
    ins[6:0]   = ($urandom_range(0, 3) == 0) ? LOAD : opcs[$urandom_range(0, 10)];
    ins[11:7]  = 5'($urandom_range(0, 7));
    ins[19:15] = 5'($urandom_range(0, 7));
    ins[24:20] = 5'($urandom_range(0, 7));
    return ins;
  endfunction

  task automatic rand_inputs();
    if_valid  = ($urandom_range(0, 3) != 0);
    if_instr  = rand_instr();
    if_pc     = {$urandom, $urandom};
    if_take   = 1'($urandom_range(0, 1));
    flush     = ($urandom_range(0, 15) == 0);
    rf_rdata1 = {$urandom, $urandom};
    rf_rdata2 = {$urandom, $urandom};
    wb_we     = 1'($urandom_range(0, 1));
    wb_rd     = 5'($urandom_range(0, 7));
    wb_data   = {$urandom, $urandom};
    ex_ready  = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    // Reset with random inputs: every registered output must read zero.
    rst_n = 1'b0;
    m = zero_model();
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      @(posedge clk);
      #1;
      check_out();
    end
    drive(1'b0, 32'h0000_0013, 64'd0, 1'b1);
    #2;
    rst_n = 1'b1;
    #1;
    chk("id_ready_after_reset", id_ready, 1'b1);

    // ADDI x1,x0,-1 on XLEN=64.
    drive(1'b1, 32'hFFF0_0093, 64'h100, 1'b1);
    step();
    chk("addi_valid", ex_valid, 1'b1);
    chk("addi_imm", ex_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_regwrite", ex_regwrite, 1'b1);
    chk("addi_aluop", ex_aluop, ALU_ADD);

    // LW x5,0(x2) then ADD x6,x5,x1: one bubble, then accepted.
    drive(1'b1, 32'h0001_2283, 64'h104, 1'b1);
    step();
    drive(1'b1, 32'h0012_8333, 64'h108, 1'b1);
    step();
    chk("loaduse_stall_ready", seen_ready, 1'b0);
    chk("loaduse_bubble", ex_valid, 1'b0);
    drive(1'b1, 32'h0012_8333, 64'h108, 1'b1);
    step();
    chk("loaduse_accept_valid", ex_valid, 1'b1);
    chk("loaduse_accept_rs1", ex_rs1, 5'd5);

    // Back-pressure: ex_ready low for three cycles holds ID/EX.
    drive(1'b1, 32'h0010_0393, 64'h200, 1'b1);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h0001_8233, 64'h204, 1'b0);
      step();
      chk("bp_ready_low", seen_ready, 1'b0);
      chk("bp_pc_hold", ex_pc, 64'h200);
    end
    drive(1'b1, 32'h0001_8233, 64'h204, 1'b1);
    step();
    chk("bp_release_pc", ex_pc, 64'h204);

    // Write-back bypass and the x0 exception.
    drive(1'b1, 32'h0001_8233, 64'h300, 1'b1);
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 64'h1234; rf_rdata1 = 64'h5555;
    step();
`ifdef ID_WB_BYPASS_EN
    chk("bypass_rs1", ex_rs1_data, 64'h1234);
`else
    chk("bypass_rs1", ex_rs1_data, 64'h5555);
`endif
    drive(1'b1, 32'h0000_0233, 64'h304, 1'b1);
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 64'h1234; rf_rdata1 = 64'h7777;
    step();
    chk("bypass_x0", ex_rs1_data, 64'h7777);

    // Illegal opcode, then flush with a live ID/EX entry.
    drive(1'b1, 32'h0000_007F, 64'h400, 1'b1);
    step();
    chk("illegal_flag", ex_illegal, 1'b1);
    chk("illegal_regwrite", ex_regwrite, 1'b0);
    drive(1'b1, 32'h0010_0393, 64'h404, 1'b1);
    flush = 1'b1;
    step();
    chk("flush_ready", seen_ready, 1'b0);
    chk("flush_valid", ex_valid, 1'b0);

    // Randomized stream, with an asynchronous reset in the middle.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        #2;
        rst_n = 1'b0;
        #1;
        m = zero_model();
        check_out();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
      end
      rand_inputs();
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
